// File: rtl/dm_responder.sv
// Data-memory responder for the M stage: fixed-latency load/store access
// with a one-cycle ready pulse, address checking and pipeline stall.
module dm_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        addr_err,
   output logic        stall
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                  state;
   logic [3:0]              cnt;
   logic                    lat_we;
   logic                    lat_err;
   logic [ADDR_WIDTH-1:0]   lat_idx;
   logic [31:0]             lat_wdata;
   logic [31:0]             mem [DEPTH];

   logic                    in_err;
   logic [ADDR_WIDTH-1:0]   in_idx;
   logic                    finish;
   logic                    f_we;
   logic                    f_err;
   logic [ADDR_WIDTH-1:0]   f_idx;
   logic [31:0]             f_wdata;

   // The access completes either straight from IDLE (single-cycle latency,
   // using live inputs) or from WAIT once the counter drains (latched values).
   always_comb begin
      in_err  = (addr[1:0] != 2'b00) || ((addr >> (ADDR_WIDTH + 2)) != 32'd0);
      in_idx  = addr[ADDR_WIDTH+1:2];
      finish  = ((state == IDLE) && req && (LATENCY == 1)) ||
                ((state == WAIT) && (cnt == 4'd0));
      f_we    = (state == IDLE) ? we     : lat_we;
      f_err   = (state == IDLE) ? in_err : lat_err;
      f_idx   = (state == IDLE) ? in_idx : lat_idx;
      f_wdata = (state == IDLE) ? wdata  : lat_wdata;
   end

   // NOTE: ready/addr_err default low every edge so they can only pulse for the RESP cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         ready     <= 1'b0;
         addr_err  <= 1'b0;
         rdata     <= 32'd0;
         lat_we    <= 1'b0;
         lat_err   <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= 32'd0;
      end else begin
         ready    <= 1'b0;
         addr_err <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  lat_we    <= we;
                  lat_err   <= in_err;
                  lat_idx   <= in_idx;
                  lat_wdata <= wdata;
                  if (LATENCY == 1) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt != 4'd0) cnt <= cnt - 4'd1;
               else             state <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
         if (finish) begin
            ready    <= 1'b1;
            addr_err <= f_err;
            if (f_err)     rdata <= 32'd0;
            else if (!f_we) rdata <= mem[f_idx];
         end
      end
   end

   // NOTE: the memory is cleared on reset, so every word gets an async reset branch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
      end else if (finish && f_we && !f_err) begin
         mem[f_idx] <= f_wdata;
      end
   end

   assign stall = req & ~ready;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: table vectors, corner-case sequences
// and randomized accesses against a word-array reference model.
module tb_dm_responder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_a, req_b, we;
   logic [31:0] addr, wdata;
   logic [31:0] rdata_a, rdata_b;
   logic        ready_a, ready_b, err_a, err_b, stall_a, stall_b;
   logic        sel;
   logic [31:0] rdata_s;
   logic        ready_s, err_s, stall_s;

   int n_pass = 0;
   int n_total = 0;

   logic [31:0] mdl_a [1024];
   logic [31:0] mdl_b [1024];
   logic [31:0] mrd_a, mrd_b;

   always #5 clk = ~clk;

   dm_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut_a (
      .clk(clk), .reset_n(reset_n), .req(req_a), .we(we), .addr(addr),
      .wdata(wdata), .rdata(rdata_a), .ready(ready_a), .addr_err(err_a),
      .stall(stall_a));

   dm_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .req(req_b), .we(we), .addr(addr),
      .wdata(wdata), .rdata(rdata_b), .ready(ready_b), .addr_err(err_b),
      .stall(stall_b));

   assign rdata_s = sel ? rdata_b : rdata_a;
   assign ready_s = sel ? ready_b : ready_a;
   assign err_s   = sel ? err_b   : err_a;
   assign stall_s = sel ? stall_b : stall_a;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic clear_model();
      for (int i = 0; i < 1024; i++) begin
         mdl_a[i] = 32'd0;
         mdl_b[i] = 32'd0;
      end
      mrd_a = 32'd0;
      mrd_b = 32'd0;
   endtask

   // Word-array model: legal iff word-aligned and inside the 4 KiB window.
   task automatic model_access(input bit s, input bit w, input logic [31:0] a,
                               input logic [31:0] d, output logic [31:0] rd,
                               output logic e);
      bit legal;
      int idx;
      legal = (a % 4 == 0) && (a < 32'h1000);
      idx   = int'(a / 4);
      if (!legal) begin
         e  = 1'b1;
         rd = 32'd0;
      end else begin
         e = 1'b0;
         if (w) begin
            if (s) mdl_b[idx] = d; else mdl_a[idx] = d;
            rd = s ? mrd_b : mrd_a;
         end else begin
            rd = s ? mdl_b[idx] : mdl_a[idx];
         end
      end
      if (s) mrd_b = rd; else mrd_a = rd;
   endtask

   // Called just after a rising edge; returns just after a rising edge with
   // one idle cycle consumed after the ready pulse.
   task automatic access(input bit s, input bit w, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd,
                         output logic e, output int lat, output int stalls);
      bit got;
      got = 1'b0;
      sel = s; we = w; addr = a; wdata = d;
      if (s) req_b = 1'b1; else req_a = 1'b1;
      lat = 0; stalls = 0; rd = 32'd0; e = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ready_s) begin
            rd  = rdata_s;
            e   = err_s;
            got = 1'b1;
            check("stall low in ready cycle", 32'(stall_s), 32'd0);
            break;
         end
         if (stall_s) stalls++;
         lat++;
         @(posedge clk); #1;
      end
      check("ready seen before timeout", 32'(got), 32'd1);
      req_a = 1'b0; req_b = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("ready single pulse", 32'(ready_s), 32'd0);
      check("addr_err low outside ready", 32'(err_s), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, exp_rd;
      logic        e, exp_e;
      int          lat, stalls, pulses, first, second, st3;
      bit          got;

      reset_n = 1'b0; req_a = 1'b0; req_b = 1'b0; sel = 1'b0;
      we = 1'b0; addr = 32'd0; wdata = 32'd0;
      clear_model();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset ready_a", 32'(ready_a), 32'd0);
      check("reset rdata_a", rdata_a, 32'd0);
      check("reset stall_a", 32'(stall_a), 32'd0);
      check("reset ready_b", 32'(ready_b), 32'd0);
      check("reset rdata_b", rdata_b, 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Reset in the middle of a store's WAIT cycle.
      access(0, 1, 32'h4, 32'h1111_1111, rd, e, lat, stalls);
      access(0, 0, 32'h4, 32'h0, rd, e, lat, stalls);
      check("pre-reset load 0x4", rd, 32'h1111_1111);
      sel = 0; we = 1; addr = 32'h8; wdata = 32'h2222_2222; req_a = 1'b1;
      @(posedge clk); #3;
      reset_n = 1'b0;
      #1;
      check("mid-wait reset ready", 32'(ready_a), 32'd0);
      check("mid-wait reset rdata", rdata_a, 32'd0);
      req_a = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      pulses = 0;
      repeat (4) begin
         @(negedge clk);
         if (ready_a) pulses++;
         @(posedge clk); #1;
      end
      check("no ready after aborted access", 32'(pulses), 32'd0);
      clear_model();
      access(0, 0, 32'h4, 32'h0, rd, e, lat, stalls);
      check("load 0x4 after reset", rd, 32'd0);
      access(0, 0, 32'h8, 32'h0, rd, e, lat, stalls);
      check("aborted store not written", rd, 32'd0);

      // Table-driven vectors on the LATENCY=2 instance.
      vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[2] = '{1'b0, 32'h0000_0013, 32'h0,         32'h0000_0000, 1'b1};
      vecs[3] = '{1'b1, 32'h0000_1000, 32'h1234_5678, 32'h0000_0000, 1'b1};
      vecs[4] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0};
      vecs[5] = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
      vecs[6] = '{1'b0, 32'h0000_0FFC, 32'h0,         32'hCAFE_F00D, 1'b0};
      vecs[7] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[8] = '{1'b1, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 1'b1};
      vecs[9] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0};
      for (int i = 0; i < 10; i++) begin
         model_access(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, exp_rd, exp_e);
         access(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, e, lat, stalls);
         check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d addr_err", i), 32'(e), 32'(vecs[i].exp_err));
         check($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
         check($sformatf("vec%0d stall cycles", i), 32'(stalls), 32'd2);
      end

      // Back-to-back: req held high across two accesses.
      sel = 0; we = 1; addr = 32'h40; wdata = 32'hA5A5_5A5A; req_a = 1'b1;
      pulses = 0; first = -1; second = -1; st3 = 0; rd = 32'd0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c == 3) st3 = int'(stall_a);
         if (ready_a) begin
            pulses++;
            if (pulses == 1) begin
               first = c;
               we = 1'b0;
            end else begin
               second = c;
               rd = rdata_a;
               req_a = 1'b0;
            end
         end
         @(posedge clk); #1;
      end
      model_access(0, 1, 32'h40, 32'hA5A5_5A5A, exp_rd, exp_e);
      model_access(0, 0, 32'h40, 32'h0, exp_rd, exp_e);
      check("b2b pulse count", 32'(pulses), 32'd2);
      check("b2b first ready cycle", 32'(first), 32'd2);
      check("b2b second ready cycle", 32'(second), 32'd5);
      check("b2b stall in bubble", 32'(st3), 32'd1);
      check("b2b load data", rd, 32'hA5A5_5A5A);

      // Inputs toggled during WAIT must not disturb the latched access.
      sel = 0; we = 1; addr = 32'h20; wdata = 32'h5; req_a = 1'b1;
      @(posedge clk); #1;
      addr = 32'h24; wdata = 32'hFFFF_FFFF; we = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (ready_a) begin
            got = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("latched store completes", 32'(got), 32'd1);
      req_a = 1'b0;
      @(posedge clk); #1;
      model_access(0, 1, 32'h20, 32'h5, exp_rd, exp_e);
      access(0, 0, 32'h20, 32'h0, rd, e, lat, stalls);
      check("latched store data", rd, 32'h5);
      access(0, 0, 32'h24, 32'h0, rd, e, lat, stalls);
      check("toggled address untouched", rd, 32'h0);
      model_access(0, 0, 32'h20, 32'h0, exp_rd, exp_e);
      model_access(0, 0, 32'h24, 32'h0, exp_rd, exp_e);

      // LATENCY=1 instance.
      model_access(1, 1, 32'h10, 32'h0BAD_F00D, exp_rd, exp_e);
      access(1, 1, 32'h10, 32'h0BAD_F00D, rd, e, lat, stalls);
      check("lat1 store latency", 32'(lat), 32'd1);
      check("lat1 store stall cycles", 32'(stalls), 32'd1);
      model_access(1, 0, 32'h10, 32'h0, exp_rd, exp_e);
      access(1, 0, 32'h10, 32'h0, rd, e, lat, stalls);
      check("lat1 load data", rd, 32'h0BAD_F00D);
      check("lat1 load latency", 32'(lat), 32'd1);

      // Randomized accesses against the model.
      for (int i = 0; i < 60; i++) begin
         bit          s, w;
         int          r;
         logic [31:0] a, d;
         s = ($urandom_range(0, 3) == 0);
         w = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 9);
         if (r == 0)      a = $urandom;
         else if (r == 1) a = 32'h100 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
         else             a = 32'h100 + 32'($urandom_range(0, 15)) * 4;
         d = $urandom;
         model_access(s, w, a, d, exp_rd, exp_e);
         access(s, w, a, d, rd, e, lat, stalls);
         check($sformatf("rand%0d rdata", i), rd, exp_rd);
         check($sformatf("rand%0d addr_err", i), 32'(e), 32'(exp_e));
         check($sformatf("rand%0d latency", i), 32'(lat), s ? 32'd1 : 32'd2);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
